// File: rtl/tpu_mmio_ctrl.sv
// tpu_mmio_ctrl: queues MMIO requests and replays them one at a time onto the TPU window port.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/wr/addr/data/tid       incoming MMIO request; req_ready = FIFO not full
//   tpu_r_w, tpu_addr, tpu_dataIn    write strobe, window offset and write data to the TPU
//   tpu_dataOut                      TPU read data, sampled READ_LAT cycles after the address
//   rsp_valid, rsp_tid, rsp_data     one-cycle read response
//   busy, ovf                        work pending / sticky dropped-request flag
module tpu_mmio_ctrl #(
    parameter int          DEPTH    = 4,
    parameter int          READ_LAT = 1,
    parameter logic [15:0] TPU_BASE = 16'h0100,
    parameter logic [15:0] TPU_SIZE = 16'h0300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [8:0]  req_tid,
    output logic        req_ready,
    output logic        tpu_r_w,
    output logic [15:0] tpu_addr,
    output logic [63:0] tpu_dataIn,
    input  logic [63:0] tpu_dataOut,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        busy,
    output logic        ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} state_e;
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
        logic [8:0]  tid;
    } req_t;

    req_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic [LW-1:0] lat_q;
    state_e        state_q, state_d;
    logic          tpu_r_w_q, rsp_valid_q, ovf_q;
    logic [15:0]   tpu_addr_q;
    logic [63:0]   tpu_data_in_q, rsp_data_q;
    logic [8:0]    rsp_tid_q;
    req_t          head;
    logic          push, pop, in_win, rd_done;

    assign head      = mem_q[rptr_q];
    // Ready comes only from the registered count, so a pop in the same cycle never makes room.
    assign req_ready = cnt_q != CW'(DEPTH);
    assign push      = req_valid & req_ready;
    assign pop       = (state_q == IDLE) && (cnt_q != '0);
    // 17-bit compare keeps TPU_BASE+TPU_SIZE from wrapping past 16'hFFFF.
    assign in_win    = ({1'b0, head.addr} >= {1'b0, TPU_BASE}) &&
                       ({1'b0, head.addr} < ({1'b0, TPU_BASE} + {1'b0, TPU_SIZE}));
    assign rd_done   = (state_q == RD_WAIT) && (lat_q == '0);

    assign tpu_r_w    = tpu_r_w_q;
    assign tpu_addr   = tpu_addr_q;
    assign tpu_dataIn = tpu_data_in_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_tid    = rsp_tid_q;
    assign rsp_data   = rsp_data_q;
    assign ovf        = ovf_q;
    assign busy       = (cnt_q != '0) || (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = head.wr ? (in_win ? WR : IDLE) : (in_win ? RD_WAIT : RESP);
            WR:      state_d = IDLE;
            RD_WAIT: if (lat_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= '{req_wr, req_addr, req_data, req_tid};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
            lat_q         <= '0;
            tpu_r_w_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            ovf_q         <= 1'b0;
            tpu_addr_q    <= '0;
            tpu_data_in_q <= '0;
            rsp_tid_q     <= '0;
            rsp_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_q + AW'(push);
            rptr_q      <= rptr_q + AW'(pop);
            cnt_q       <= cnt_q + CW'(push) - CW'(pop);
            ovf_q       <= ovf_q | (req_valid & ~req_ready);
            tpu_r_w_q   <= state_d == WR;
            rsp_valid_q <= state_d == RESP;
            if (pop && in_win) begin
                tpu_addr_q <= head.addr - TPU_BASE;
                if (head.wr) tpu_data_in_q <= head.data;
            end
            if (pop && !head.wr) rsp_tid_q <= head.tid;
            if (pop && !head.wr && !in_win) rsp_data_q <= '0;
            if (rd_done) rsp_data_q <= tpu_dataOut;
            // lat_q counts the remaining RD_WAIT cycles; it is armed on every pop.
            if (pop) lat_q <= LW'(READ_LAT - 1);
            else if (state_q == RD_WAIT) lat_q <= lat_q - LW'(1);
        end
    end
endmodule

// File: tb/tb_tpu_mmio_ctrl.sv
// tb_tpu_mmio_ctrl: scoreboard bench for tpu_mmio_ctrl with a fast-read and a slow-read instance.
module tb_tpu_mmio_ctrl;
    logic        clk, rst;
    logic        a_req_valid, a_req_wr, b_req_valid, b_req_wr;
    logic [15:0] a_req_addr, b_req_addr;
    logic [63:0] a_req_data, b_req_data;
    logic [8:0]  a_req_tid, b_req_tid;
    logic        a_req_ready, a_tpu_r_w, a_rsp_valid, a_busy, a_ovf;
    logic        b_req_ready, b_tpu_r_w, b_rsp_valid, b_busy, b_ovf;
    logic [15:0] a_tpu_addr, b_tpu_addr;
    logic [63:0] a_tpu_dataIn, b_tpu_dataIn, a_dout, b_dout, a_rsp_data, b_rsp_data;
    logic [8:0]  a_rsp_tid, b_rsp_tid;

    int checks = 0;
    int errors = 0;
    logic [79:0] wq_a[$], wq_b[$];
    logic [72:0] rq_a[$], rq_b[$];

    // TPU read model: data is a fixed function of the window offset (offset 5 -> 64'h1234).
    assign a_dout = 64'h122F + {48'h0, a_tpu_addr};
    assign b_dout = 64'h122F + {48'h0, b_tpu_addr};

    tpu_mmio_ctrl u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_wr(a_req_wr), .req_addr(a_req_addr),
        .req_data(a_req_data), .req_tid(a_req_tid), .req_ready(a_req_ready),
        .tpu_r_w(a_tpu_r_w), .tpu_addr(a_tpu_addr), .tpu_dataIn(a_tpu_dataIn),
        .tpu_dataOut(a_dout), .rsp_valid(a_rsp_valid), .rsp_tid(a_rsp_tid),
        .rsp_data(a_rsp_data), .busy(a_busy), .ovf(a_ovf)
    );

    tpu_mmio_ctrl #(.READ_LAT(8)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_wr(b_req_wr), .req_addr(b_req_addr),
        .req_data(b_req_data), .req_tid(b_req_tid), .req_ready(b_req_ready),
        .tpu_r_w(b_tpu_r_w), .tpu_addr(b_tpu_addr), .tpu_dataIn(b_tpu_dataIn),
        .tpu_dataOut(b_dout), .rsp_valid(b_rsp_valid), .rsp_tid(b_rsp_tid),
        .rsp_data(b_rsp_data), .busy(b_busy), .ovf(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input bit wr, input logic [15:0] addr,
                        input logic [63:0] data, input logic [8:0] tid);
        if (!sel) begin
            a_req_valid = 1'b1; a_req_wr = wr; a_req_addr = addr; a_req_data = data; a_req_tid = tid;
        end else begin
            b_req_valid = 1'b1; b_req_wr = wr; b_req_addr = addr; b_req_data = data; b_req_tid = tid;
        end
        tick();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (a_tpu_r_w) begin
            if (wq_a.size() == 0) chk("a_write_unexpected", 80'(a_tpu_r_w), 80'd0);
            else chk("a_write", {a_tpu_addr, a_tpu_dataIn}, wq_a.pop_front());
        end
        if (a_rsp_valid) begin
            if (rq_a.size() == 0) chk("a_rsp_unexpected", 80'(a_rsp_valid), 80'd0);
            else chk("a_rsp", 80'({a_rsp_tid, a_rsp_data}), 80'(rq_a.pop_front()));
        end
        if (b_tpu_r_w) begin
            if (wq_b.size() == 0) chk("b_write_unexpected", 80'(b_tpu_r_w), 80'd0);
            else chk("b_write", {b_tpu_addr, b_tpu_dataIn}, wq_b.pop_front());
        end
        if (b_rsp_valid) begin
            if (rq_b.size() == 0) chk("b_rsp_unexpected", 80'(b_rsp_valid), 80'd0);
            else chk("b_rsp", 80'({b_rsp_tid, b_rsp_data}), 80'(rq_b.pop_front()));
        end
    end

    initial begin
        {a_req_valid, a_req_wr, a_req_addr, a_req_data, a_req_tid} = '0;
        {b_req_valid, b_req_wr, b_req_addr, b_req_data, b_req_tid} = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", 80'(a_req_ready), 80'd1);
        chk("rst_busy_ovf", 80'({a_busy, a_ovf}), 80'd0);
        chk("rst_r_w", 80'(a_tpu_r_w), 80'd0);
        chk("rst_tpu", {a_tpu_addr, a_tpu_dataIn}, 80'd0);
        chk("rst_rsp", 80'({a_rsp_valid, a_rsp_tid, a_rsp_data}), 80'd0);
        rst = 1'b0;
        tick();

        // In-window write: strobe in cycle 2 only.
        wq_a.push_back({16'h0020, 64'hDEAD_BEEF});
        send(0, 1'b1, 16'h0120, 64'hDEAD_BEEF, 9'h000);
        chk("wr_busy_c1", 80'(a_busy), 80'd1);
        chk("wr_r_w_c1", 80'(a_tpu_r_w), 80'd0);
        tick();
        chk("wr_r_w_c2", 80'(a_tpu_r_w), 80'd1);
        chk("wr_tpu_c2", {a_tpu_addr, a_tpu_dataIn}, {16'h0020, 64'hDEAD_BEEF});
        tick();
        chk("wr_r_w_c3", 80'(a_tpu_r_w), 80'd0);
        tick();

        // In-window read, READ_LAT=1: response in cycle 3.
        rq_a.push_back({9'h05A, 64'h1234});
        send(0, 1'b0, 16'h0105, 64'h0, 9'h05A);
        tick();
        chk("rd_valid_c2", 80'(a_rsp_valid), 80'd0);
        chk("rd_addr_c2", 80'(a_tpu_addr), 80'h0005);
        tick();
        chk("rd_valid_c3", 80'(a_rsp_valid), 80'd1);
        tick();

        // Out-of-window read answers zero in cycle 2 without touching tpu_addr.
        rq_a.push_back({9'h011, 64'h0});
        send(0, 1'b0, 16'h0400, 64'h0, 9'h011);
        tick();
        chk("oow_rd_valid_c2", 80'(a_rsp_valid), 80'd1);
        chk("oow_rd_addr", 80'(a_tpu_addr), 80'h0005);
        tick();

        // Out-of-window write below the base is discarded.
        send(0, 1'b1, 16'h00FF, 64'h55, 9'h000);
        repeat (4) tick();
        chk("oow_wr_tpu", {a_tpu_addr, a_tpu_dataIn}, {16'h0005, 64'hDEAD_BEEF});
        chk("oow_wr_busy", 80'(a_busy), 80'd0);

        // Window edges: last address, first address, top of address space.
        wq_a.push_back({16'h02FF, 64'h77});
        send(0, 1'b1, 16'h03FF, 64'h77, 9'h000);
        repeat (3) tick();
        rq_a.push_back({9'h1FF, 64'h122F});
        send(0, 1'b0, 16'h0100, 64'h0, 9'h1FF);
        repeat (4) tick();
        rq_a.push_back({9'h0AA, 64'h0});
        send(0, 1'b0, 16'hFFFF, 64'h0, 9'h0AA);
        repeat (3) tick();
        chk("edge_tpu_addr", 80'(a_tpu_addr), 80'h0000);

        // Slow instance: stall in RD_WAIT, then five back-to-back requests; the fifth is dropped.
        rq_b.push_back({9'h001, 64'h123F});
        send(1, 1'b0, 16'h0110, 64'h0, 9'h001);
        tick();
        wq_b.push_back({16'h0100, 64'hB});
        send(1, 1'b1, 16'h0200, 64'hB, 9'h000);
        rq_b.push_back({9'h002, 64'h1230});
        send(1, 1'b0, 16'h0101, 64'h0, 9'h002);
        wq_b.push_back({16'h0200, 64'hD});
        send(1, 1'b1, 16'h0300, 64'hD, 9'h000);
        rq_b.push_back({9'h003, 64'h0});
        send(1, 1'b0, 16'h0400, 64'h0, 9'h003);
        chk("full_ready", 80'(b_req_ready), 80'd0);
        chk("full_ovf_before", 80'(b_ovf), 80'd0);
        send(1, 1'b1, 16'h0111, 64'hF, 9'h000);
        chk("full_ovf_after", 80'(b_ovf), 80'd1);
        repeat (60) tick();
        chk("drain_ovf_busy", 80'({b_ovf, b_busy}), 80'b10);

        // Reset while in RD_WAIT with two entries queued.
        send(1, 1'b0, 16'h0120, 64'h0, 9'h007);
        tick();
        send(1, 1'b0, 16'h0130, 64'h0, 9'h008);
        send(1, 1'b1, 16'h0140, 64'h9, 9'h000);
        chk("pre_rst_busy", 80'(b_busy), 80'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_flags", 80'({b_req_ready, b_busy, b_ovf, b_tpu_r_w, b_rsp_valid}), 80'b10000);
        chk("mid_rst_tpu", {b_tpu_addr, b_tpu_dataIn}, 80'd0);
        chk("mid_rst_rsp", 80'({b_rsp_tid, b_rsp_data}), 80'd0);
        rst = 1'b0;
        repeat (20) tick();
        chk("post_rst_busy", 80'(b_busy), 80'd0);

        chk("a_writes_left", 80'(wq_a.size()), 80'd0);
        chk("a_rsps_left", 80'(rq_a.size()), 80'd0);
        chk("b_writes_left", 80'(wq_b.size()), 80'd0);
        chk("b_rsps_left", 80'(rq_b.size()), 80'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
